// File: rtl/axi_lite_prodcons_slave.sv
// AXI4-Lite slave with four scratch registers, a producer/consumer mailbox
// FIFO and a status register with sticky overflow/underflow flags.
module axi_lite_prodcons_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH         = 8
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW    = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] A_MBOX   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  // Per-channel handshake sequencing: idle -> ready pulse -> response held.
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_ACC  = 2'd1,
    CH_RESP = 2'd2
  } ch_state_e;

  ch_state_e        wstate_q, wstate_d;
  ch_state_e        rstate_q, rstate_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [DW-1:0]    scratch_q [4];
  logic [DW-1:0]    scratch_d [4];
  logic [DW-1:0]    mem_q [FIFO_DEPTH];
  logic [DW-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             wr_en, rd_en;
  logic             push, pop;
  logic             ovf_set, ovf_clr, unf_set, unf_clr;
  logic             fifo_full, fifo_empty;
  logic [2:0]       waddr, raddr;
  logic [DW-1:0]    status;

  logic             unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign waddr      = S_AXI_AWADDR[4:2];
  assign raddr      = S_AXI_ARADDR[4:2];
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Status word assembled from the pre-edge FIFO and flag state.
  always_comb begin
    status      = '0;
    status[8:0] = 9'(count_q);
    status[16]  = fifo_empty;
    status[17]  = fifo_full;
    status[24]  = ovf_q;
    status[25]  = unf_q;
  end

  // Write channel sequencing and register/mailbox write decode.
  always_comb begin
    wstate_d  = wstate_q;
    bresp_d   = bresp_q;
    scratch_d = scratch_q;
    wr_en     = 1'b0;
    push      = 1'b0;
    ovf_set   = 1'b0;
    ovf_clr   = 1'b0;
    unf_clr   = 1'b0;
    case (wstate_q)
      CH_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) wstate_d = CH_ACC;
      CH_ACC: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          wr_en    = 1'b1;
          wstate_d = CH_RESP;
        end else begin
          wstate_d = CH_IDLE;
        end
      end
      CH_RESP: begin
        if (S_AXI_BREADY) wstate_d = (S_AXI_AWVALID && S_AXI_WVALID) ? CH_ACC : CH_IDLE;
      end
      default: wstate_d = CH_IDLE;
    endcase
    if (wr_en) begin
      case (waddr)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          for (int b = 0; b < int'(SW); b++) begin
            if (S_AXI_WSTRB[b]) scratch_d[waddr[1:0]][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
          end
          bresp_d = RESP_OKAY;
        end
        A_MBOX: begin
          if (!fifo_full && (S_AXI_WSTRB == '1)) begin
            push    = 1'b1;
            bresp_d = RESP_OKAY;
          end else begin
            ovf_set = fifo_full;
            bresp_d = RESP_SLVERR;
          end
        end
        A_STATUS: begin
          ovf_clr = S_AXI_WSTRB[3] & S_AXI_WDATA[24];
          unf_clr = S_AXI_WSTRB[3] & S_AXI_WDATA[25];
          bresp_d = RESP_OKAY;
        end
        default: bresp_d = RESP_DECERR;
      endcase
    end
  end

  // Read channel sequencing and read data/response capture.
  always_comb begin
    rstate_d = rstate_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    rd_en    = 1'b0;
    pop      = 1'b0;
    unf_set  = 1'b0;
    case (rstate_q)
      CH_IDLE: if (S_AXI_ARVALID) rstate_d = CH_ACC;
      CH_ACC: begin
        if (S_AXI_ARVALID) begin
          rd_en    = 1'b1;
          rstate_d = CH_RESP;
        end else begin
          rstate_d = CH_IDLE;
        end
      end
      CH_RESP: begin
        if (S_AXI_RREADY) rstate_d = S_AXI_ARVALID ? CH_ACC : CH_IDLE;
      end
      default: rstate_d = CH_IDLE;
    endcase
    if (rd_en) begin
      case (raddr)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          rdata_d = scratch_q[raddr[1:0]];
          rresp_d = RESP_OKAY;
        end
        A_MBOX: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            rdata_d = mem_q[rptr_q];
            rresp_d = RESP_OKAY;
          end else begin
            unf_set = 1'b1;
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
        A_STATUS: begin
          rdata_d = status;
          rresp_d = RESP_OKAY;
        end
        default: begin
          rdata_d = '0;
          rresp_d = RESP_DECERR;
        end
      endcase
    end
  end

  // Mailbox FIFO bookkeeping; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = S_AXI_WDATA;
    wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d   = (ovf_q & ~ovf_clr) | ovf_set;
    unf_d   = (unf_q & ~unf_clr) | unf_set;
  end

  // Control and register state with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q  <= CH_IDLE;
      rstate_q  <= CH_IDLE;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      scratch_q <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      scratch_q <= scratch_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Mailbox storage; contents are only meaningful under the count.
  always_ff @(posedge ACLK) begin
    mem_q <= mem_d;
  end

  assign S_AXI_AWREADY = (wstate_q == CH_ACC);
  assign S_AXI_WREADY  = (wstate_q == CH_ACC);
  assign S_AXI_BVALID  = (wstate_q == CH_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (rstate_q == CH_ACC);
  assign S_AXI_RVALID  = (rstate_q == CH_RESP);
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: doc/axi_lite_prodcons_slave.md
AXI_LITE_PRODCONS_SLAVE -- requirements
Module: axi_lite_prodcons_slave

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width; decode uses bits [4:2].
REQ-003 Parameter FIFO_DEPTH, default 8, mailbox depth; power of 2 in 2..256.
REQ-004 ACLK  in  1  single clock; all logic on rising edge.
REQ-005 ARESET  in  1  synchronous, active-high reset.
REQ-006 S_AXI_AWADDR in 5, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write address channel.
REQ-007 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1  write data channel.
REQ-008 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  write response channel.
REQ-009 S_AXI_ARADDR in 5, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  read address channel.
REQ-010 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1  read data channel.

Function
REQ-011 Register map: 0x00-0x0C SCRATCH0-3 (RW), 0x10 MBOX (write=push, read=pop), 0x14 STATUS; 0x18/0x1C are unmapped.
REQ-012 Write accept: when AWVALID&WVALID and BVALID=0, AWREADY and WREADY pulse high together for exactly one cycle; the register update occurs on that same edge.
REQ-013 Write response: BVALID rises the cycle after acceptance, is held with a stable BRESP until BREADY, and no new write is accepted while BVALID=1.
REQ-014 Read accept: when ARVALID and RVALID=0, ARREADY pulses for one cycle; RVALID rises the next cycle with RDATA/RRESP, held stable until RREADY.
REQ-015 Back-to-back throughput is one write per 2 cycles and one read per 2 cycles when BREADY/RREADY are held high; read and write paths are independent and may complete in the same cycle.
REQ-016 SCRATCHn writes honour WSTRB per byte; BRESP=OKAY (2'b00).
REQ-017 MBOX write with FIFO not full and WSTRB=4'hF pushes WDATA and returns OKAY.
REQ-018 MBOX write with FIFO full, or with WSTRB!=4'hF, drops the data and returns SLVERR (2'b10); the full case also sets STATUS.OVF.
REQ-019 MBOX read with FIFO not empty returns the head word with OKAY and pops it on the ARREADY edge.
REQ-020 MBOX read with FIFO empty returns RDATA=0 with SLVERR and sets STATUS.UNF.
REQ-021 Same-cycle push and pop: full/empty are evaluated on the pre-edge state; push into a full FIFO is rejected even if a pop occurs; pop from an empty FIFO fails even if a push occurs; when both succeed, count is unchanged.
REQ-022 FIFO pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1 and ranges 0..FIFO_DEPTH.
REQ-023 STATUS fields: [8:0] count (zero-extended), [16] empty, [17] full, [24] OVF sticky, [25] UNF sticky; all other bits read 0.
REQ-024 STATUS write: writing 1 to bit 24 or 25 with WSTRB[3]=1 clears that bit (W1C), other bits are ignored, BRESP=OKAY; a same-cycle set takes priority over the clear.
REQ-025 Unmapped reads return RDATA=0 with DECERR (2'b11); unmapped writes have no effect and return DECERR.

Reset
REQ-026 While ARESET=1 at an edge: AWREADY, WREADY, ARREADY, BVALID and RVALID are 0; BRESP, RRESP and RDATA are 0; SCRATCH0-3 are 0; the FIFO is emptied (count 0, empty 1); OVF and UNF are 0.
REQ-027 Reset asserted mid-transaction abandons any pending B/R response with no further VALID; the first transaction after reset release is accepted normally.

Verification
REQ-028 Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x00/04/08/0C, each read back -> identical data, all responses OKAY.
REQ-029 Write 0xFFFFFFFF to 0x04 with WSTRB=4'b0101 after 0 -> readback 0x00FF00FF.
REQ-030 With FIFO_DEPTH=8: push 9 words 1..9 -> 9th BRESP=SLVERR, STATUS=0x0102_0008; 8 pops return 1..8 OKAY; 9th pop RDATA=0 SLVERR; STATUS=0x0301_0000.
REQ-031 Write 0x0300_0000 to 0x14 -> STATUS reads 0x0001_0000.
REQ-032 Concurrent MBOX write and read with count=3, BREADY/RREADY high -> both OKAY, count stays 3; BREADY held low 10 cycles -> BVALID and BRESP stable, AWREADY stays 0.
REQ-033 Read 0x18 -> DECERR, RDATA=0; ARESET pulse while RVALID=1 -> RVALID=0 next edge, STATUS=0x0001_0000.
